esfa_op_sequencer: RTL

//  Sits directly downstream of the root of the NodeCombinator reduction tree and upstream of the host.

---
 rtl/esfa_pkg.sv | 28 ++
 rtl/esfa_wait_timer.sv | 54 +++++
 rtl/esfa_op_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/esfa_pkg.sv
// Shared constants for the ESFA operation sequencer: host opcodes, sequencer state
// encoding and the default bus width.
package esfa_pkg;

   localparam int ESFA_DW = 8;

   localparam int unsigned OP_UPDATE       = 0;
   localparam int unsigned OP_LOOKUP_SCAN  = 1;
   localparam int unsigned OP_LOOKUP_FINAL = 2;
   localparam int unsigned OP_ENCODE       = 3;
   localparam int unsigned OP_DELETE       = 4;
   localparam int unsigned OP_CONGRUE_UP   = 5;
   localparam int unsigned OP_CONGRUE_DOWN = 6;
   localparam int unsigned OP_MARK_AVAIL   = 7;

   localparam logic [2:0] SEQ_IDLE   = 3'd0;
   localparam logic [2:0] SEQ_ISSUE  = 3'd1;
   localparam logic [2:0] SEQ_WAIT   = 3'd2;
   localparam logic [2:0] SEQ_ISSUE2 = 3'd3;
   localparam logic [2:0] SEQ_WAIT2  = 3'd4;
   localparam logic [2:0] SEQ_RESP   = 3'd5;

   // Congruence moves only reshuffle cells, so the tree root carries no meaningful payload
   function automatic logic isVoidOp(input int unsigned op);
      return (op == OP_CONGRUE_UP) || (op == OP_CONGRUE_DOWN);
   endfunction

endpackage

// File: rtl/esfa_wait_timer.sv
// Per-phase wait timing: a guard window that masks stale root_done after a start pulse,
// plus an optional give-up counter enabled by ESFA_SEQ_TIMEOUT_EN.
module esfa_wait_timer #(
   parameter int GUARD_CYC   = 2,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic waiting,
   output logic guard_busy
`ifdef ESFA_SEQ_TIMEOUT_EN
   ,
   output logic timed_out
`endif
);

   localparam int GW = $clog2(GUARD_CYC + 2);

   logic [GW-1:0] guardCnt;

   // Reloaded on every start pulse; cells need these cycles to drop their old opDone
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         guardCnt <= '0;
      end else if (load) begin
         guardCnt <= GW'(GUARD_CYC);
      end else if (waiting && (guardCnt != '0)) begin
         guardCnt <= guardCnt - GW'(1);
      end
   end

   assign guard_busy = (guardCnt != '0);

`ifdef ESFA_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] waitCnt;

   // Counts every cycle spent waiting in the current phase, saturating at the limit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         waitCnt <= '0;
      end else if (load) begin
         waitCnt <= '0;
      end else if (waiting && !timed_out) begin
         waitCnt <= waitCnt + TW'(1);
      end
   end

   assign timed_out = waiting && (waitCnt == TW'(TIMEOUT_CYC));
`endif

endmodule

// File: rtl/esfa_op_sequencer.sv
// Host-side command sequencer for the ESFA cell array and NodeCombinator tree.
// Define ESFA_SEQ_TIMEOUT_EN to add a per-phase timeout reported on rsp_timeout.
module esfa_op_sequencer
   import esfa_pkg::*;
#(
   parameter int DW          = ESFA_DW,
   parameter int GUARD_CYC   = 2,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [DW-1:0] cmd_op,
   input  logic [DW-1:0] cmd_arg,
   output logic          op_start,
   output logic [DW-1:0] op_selector,
   output logic [DW-1:0] op_arg,
   input  logic [DW-1:0] root_value,
   input  logic [DW-1:0] root_context,
   input  logic          root_bool,
   input  logic          root_done,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_value,
   output logic [DW-1:0] rsp_context,
   output logic          rsp_found,
   output logic          rsp_timeout
);

   logic [2:0]    state;
   logic [DW-1:0] opSel;
   logic [DW-1:0] opArg;
   logic [DW-1:0] rspValue;
   logic [DW-1:0] rspContext;
   logic          rspFound;
   logic          inIssue;
   logic          inWait;
   logic          guardBusy;
   logic          phaseDone;

   assign inIssue   = (state == SEQ_ISSUE) || (state == SEQ_ISSUE2);
   assign inWait    = (state == SEQ_WAIT)  || (state == SEQ_WAIT2);
   assign phaseDone = inWait && !guardBusy && root_done;

`ifdef ESFA_SEQ_TIMEOUT_EN
   logic timedOut;
   logic rspTimeout;
`endif

   esfa_wait_timer #(
      .GUARD_CYC   (GUARD_CYC),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) waitTimer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (inIssue),
      .waiting    (inWait),
      .guard_busy (guardBusy)
`ifdef ESFA_SEQ_TIMEOUT_EN
      ,
      .timed_out  (timedOut)
`endif
   );

   // Command flow; a found lookup scan re-issues itself as a finalizer at the winning context
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= SEQ_IDLE;
         opSel      <= '0;
         opArg      <= '0;
         rspValue   <= '0;
         rspContext <= '0;
         rspFound   <= 1'b0;
`ifdef ESFA_SEQ_TIMEOUT_EN
         rspTimeout <= 1'b0;
`endif
      end else begin
         case (state)
            SEQ_IDLE: begin
               if (cmd_valid) begin
                  opSel <= cmd_op;
                  opArg <= cmd_arg;
                  state <= SEQ_ISSUE;
               end
            end
            SEQ_ISSUE: state <= SEQ_WAIT;
            SEQ_WAIT: begin
               if (phaseDone) begin
                  if (opSel == DW'(OP_LOOKUP_SCAN)) begin
                     if (root_bool) begin
                        opSel <= DW'(OP_LOOKUP_FINAL);
                        opArg <= root_context;
                        state <= SEQ_ISSUE2;
                     end else begin
                        rspValue   <= '0;
                        rspContext <= '0;
                        rspFound   <= 1'b0;
                        state      <= SEQ_RESP;
                     end
                  end else if (isVoidOp(32'(opSel))) begin
                     rspValue   <= '0;
                     rspContext <= '0;
                     rspFound   <= 1'b0;
                     state      <= SEQ_RESP;
                  end else begin
                     rspValue   <= root_value;
                     rspContext <= root_context;
                     rspFound   <= root_bool;
                     state      <= SEQ_RESP;
                  end
               end
`ifdef ESFA_SEQ_TIMEOUT_EN
               else if (timedOut) begin
                  rspValue   <= '0;
                  rspContext <= '0;
                  rspFound   <= 1'b0;
                  rspTimeout <= 1'b1;
                  state      <= SEQ_RESP;
               end
`endif
            end
            SEQ_ISSUE2: state <= SEQ_WAIT2;
            SEQ_WAIT2: begin
               if (phaseDone) begin
                  rspValue   <= root_value;
                  rspContext <= root_context;
                  rspFound   <= root_bool;
                  state      <= SEQ_RESP;
               end
`ifdef ESFA_SEQ_TIMEOUT_EN
               else if (timedOut) begin
                  rspValue   <= '0;
                  rspContext <= '0;
                  rspFound   <= 1'b0;
                  rspTimeout <= 1'b1;
                  state      <= SEQ_RESP;
               end
`endif
            end
            SEQ_RESP: begin
               if (rsp_ready) begin
                  state <= SEQ_IDLE;
`ifdef ESFA_SEQ_TIMEOUT_EN
                  rspTimeout <= 1'b0;
`endif
               end
            end
            default: state <= SEQ_IDLE;
         endcase
      end
   end

   assign cmd_ready   = (state == SEQ_IDLE);
   assign op_start    = inIssue;
   assign op_selector = opSel;
   assign op_arg      = opArg;
   assign rsp_valid   = (state == SEQ_RESP);
   assign rsp_value   = rspValue;
   assign rsp_context = rspContext;
   assign rsp_found   = rspFound;

`ifdef ESFA_SEQ_TIMEOUT_EN
   assign rsp_timeout = rspTimeout;
`else
   assign rsp_timeout = 1'b0;
`endif

endmodule
